// File: rtl/mux_pkg.sv
// Shared mode encodings and helpers for the N:1 registered mux and its arbiter.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Widest one-hot vector the index helper accepts; callers zero-extend.
  localparam int MAX_CH = 64;

  // OR-folds the positions of set bits, so a true one-hot input yields its index.
  function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester after 'last', wrapping modulo N_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [2*N_CH-1:0] dbl;
  logic [2*N_CH-1:0] masked;
  logic [2*N_CH-1:0] lowest;
  logic [N_CH-1:0]   oh;
  logic [MAX_CH-1:0] oh_ext;

  // The request vector is doubled so that masking off positions up to 'last'
  // leaves a window that starts just after 'last' and wraps through channel 'last'.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2*N_CH; i++) begin
      masked[i] = dbl[i] & (i > int'(last));
    end
    lowest  = masked & (-masked);
    oh      = lowest[N_CH-1:0] | lowest[2*N_CH-1:N_CH];
    oh_ext  = '0;
    oh_ext[N_CH-1:0] = oh;
    gnt_idx = SEL_W'(onehot_to_idx(oh_ext));
    gnt_vld = |req;
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-channel registered mux with valid/ready on every port; direct-select or round-robin.
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter  int N_CH   = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  last;
  logic [SEL_W-1:0]  rr_gnt;
  logic              rr_vld;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              sel_vld;
  logic              slot_free;
  logic              xfer;
  logic [DATA_W-1:0] gnt_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .last    (last),
    .gnt_idx (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // Channel matching by loop means an out-of-range sel simply never matches.
  always_comb begin
    sel_vld  = 1'b0;
    gnt_data = '0;
    in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == sel) sel_vld = in_valid[k];
    end
    if (mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else begin
      gnt     = sel;
      gnt_vld = sel_vld;
    end
    slot_free = !out_valid || out_ready;
    xfer      = rst_n && slot_free && gnt_vld;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == gnt) begin
        in_ready[k] = xfer;
        gnt_data    = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A load takes priority over a drain, giving back-to-back beats with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SEL_W'(N_CH-1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt;
      last      <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
